weight_fetch_unit: RTL and testbench

Weight fetch stage directly upstream of the weight holding register in front of the systolic array. It reads packed weight words (one F_WIDTH lane per array row) from the weight memory over a configurable number of rounds and unpacks each word into a per-row signed vector. It presents each vector with a valid flag until the controller's `rd_weight_ld` pulse consumes it. It flags end of each round and end of all weights to the controller.

---
 rtl/weight_fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_weight_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_unit.sv
// Weight fetch stage: reads packed weight words round by round and presents each unpacked vector until consumed.
// Optional build macro WEIGHT_ZERO_SKIP_EN: all-zero words are skipped in WAIT instead of being presented.
module weight_fetch_unit #(
    parameter int N_ROWS_ARRAY        = 4,
    parameter int F_WIDTH             = 8,
    parameter int WEIGHT_ADDR_WIDTH   = 6,
    parameter int COUNTER_ROUND_WIDTH = 3
) (
    input  logic                                clk_i,
    input  logic                                rd_weight_rst,
    input  logic                                start_i,
    input  logic [COUNTER_ROUND_WIDTH:0]        n_round_weight_i,
    input  logic [WEIGHT_ADDR_WIDTH-1:0]        words_per_round_i,
    output logic                                mem_rd_o,
    output logic [WEIGHT_ADDR_WIDTH-1:0]        mem_addr_o,
    input  logic [F_WIDTH*N_ROWS_ARRAY-1:0]     mem_data_i,
    input  logic                                rd_weight_ld_i,
    output logic                                weight_valid_o,
    output logic signed [F_WIDTH-1:0]           f_weight_o [0:N_ROWS_ARRAY-1],
    output logic [COUNTER_ROUND_WIDTH:0]        round_o,
    output logic                                end_round_o,
    output logic                                end_weight_o,
    output logic                                busy_o
);

    localparam int RW = COUNTER_ROUND_WIDTH + 1;
    localparam int AW = WEIGHT_ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   nr_q, nr_d;
    logic [RW-1:0]   round_q, round_d;
    logic [AW-1:0]   wpr_q, wpr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   word_q, word_d;
    logic            end_round_q, end_round_d;
    logic            end_weight_q;
    logic            weight_valid_q;
    logic            busy_q;
    logic            capture;
    logic            advance;
    logic            word_last;
    logic            round_last;

    assign word_last  = (word_q + 1'b1) == wpr_q;
    assign round_last = (round_q + 1'b1) == nr_q;

    // Next-state and counter logic; "advance" is the common word-retire path
    // shared by a consumed word and (optionally) a skipped zero word.
    always_comb begin
        state_d     = state_q;
        nr_d        = nr_q;
        wpr_d       = wpr_q;
        addr_d      = addr_q;
        word_d      = word_q;
        round_d     = round_q;
        end_round_d = 1'b0;
        capture     = 1'b0;
        advance     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    nr_d    = n_round_weight_i;
                    wpr_d   = words_per_round_i;
                    addr_d  = '0;
                    word_d  = '0;
                    round_d = '0;
                    if ((n_round_weight_i == '0) || (words_per_round_i == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
`ifdef WEIGHT_ZERO_SKIP_EN
                if (mem_data_i == '0) begin
                    advance = 1'b1;
                end else begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
`else
                capture = 1'b1;
                state_d = HOLD;
`endif
            end
            HOLD: begin
                if (rd_weight_ld_i) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            addr_d = addr_q + 1'b1;
            if (word_last) begin
                word_d      = '0;
                round_d     = round_q + 1'b1;
                end_round_d = 1'b1;
                state_d     = round_last ? DONE : FETCH;
            end else begin
                word_d  = word_q + 1'b1;
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            state_q        <= IDLE;
            nr_q           <= '0;
            wpr_q          <= '0;
            addr_q         <= '0;
            word_q         <= '0;
            round_q        <= '0;
            end_round_q    <= 1'b0;
            end_weight_q   <= 1'b0;
            weight_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            nr_q           <= nr_d;
            wpr_q          <= wpr_d;
            addr_q         <= addr_d;
            word_q         <= word_d;
            round_q        <= round_d;
            end_round_q    <= end_round_d;
            end_weight_q   <= (state_d == DONE);
            weight_valid_q <= (state_d == HOLD);
            busy_q         <= (state_d == FETCH) || (state_d == WAIT) || (state_d == HOLD);
        end
    end

    // Lanes keep their value after transfer; only a WAIT capture updates them.
    genvar gi;
    generate
        for (gi = 0; gi < N_ROWS_ARRAY; gi++) begin : g_lane
            logic signed [F_WIDTH-1:0] lane_q;
            always_ff @(posedge clk_i or posedge rd_weight_rst) begin
                if (rd_weight_rst) begin
                    lane_q <= '0;
                end else if (capture) begin
                    lane_q <= mem_data_i[gi*F_WIDTH +: F_WIDTH];
                end
            end
            assign f_weight_o[gi] = lane_q;
        end
    endgenerate

    assign mem_rd_o       = (state_q == FETCH);
    assign mem_addr_o     = (state_q == FETCH) ? addr_q : '0;
    assign weight_valid_o = weight_valid_q;
    assign round_o        = round_q;
    assign end_round_o    = end_round_q;
    assign end_weight_o   = end_weight_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_weight_fetch_unit.sv
// Scoreboard bench for weight_fetch_unit: expected addresses/words/round ends are queued per run
// and compared by a negedge monitor as the DUT reads memory, transfers words and ends rounds.
`timescale 1ns/1ps
module tb_weight_fetch_unit;

    localparam int NR = 4;
    localparam int FW = 8;
    localparam int AW = 6;
    localparam int CW = 3;
`ifdef WEIGHT_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   ld;
    logic [CW:0]            n_round;
    logic [AW-1:0]          wpr;
    logic                   mem_rd;
    logic [AW-1:0]          mem_addr;
    logic [FW*NR-1:0]       mem_data;
    logic                   valid;
    logic signed [FW-1:0]   f_w [0:NR-1];
    logic [CW:0]            round;
    logic                   end_round;
    logic                   end_weight;
    logic                   busy;

    logic [FW*NR-1:0]       mem [0:63];

    int n_vec = 0;
    int n_err = 0;
    int presented = 0;
    int          addr_q [$];
    logic [31:0] word_q [$];
    int          rnd_q  [$];
    int          er_q   [$];

    always #5 clk = ~clk;

    weight_fetch_unit #(
        .N_ROWS_ARRAY(NR), .F_WIDTH(FW), .WEIGHT_ADDR_WIDTH(AW), .COUNTER_ROUND_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rd_weight_rst(rst), .start_i(start),
        .n_round_weight_i(n_round), .words_per_round_i(wpr),
        .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
        .rd_weight_ld_i(ld), .weight_valid_o(valid), .f_weight_o(f_w),
        .round_o(round), .end_round_o(end_round), .end_weight_o(end_weight), .busy_o(busy)
    );

    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fpack();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) r[i*FW +: FW] = f_w[i];
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd) begin
                if (addr_q.size() == 0) check("rd_unexpected", 1, 0);
                else check("mem_addr", mem_addr, addr_q.pop_front());
            end
            if (valid && ld) begin
                if (word_q.size() == 0) check("xfer_unexpected", 1, 0);
                else begin
                    check("f_weight", fpack(), word_q.pop_front());
                    check("round_o", round, rnd_q.pop_front());
                end
                presented++;
            end
            if (end_round) begin
                if (er_q.size() == 0) check("end_round_unexpected", 1, 0);
                else begin
                    check("end_round_at", presented, er_q.pop_front());
                    check("end_weight_at_round", end_weight, (er_q.size() == 0));
                end
            end
        end
    end

    task automatic plan(input int nr, input int w, output int np, output int ns);
        int pres;
        int k;
        int a;
        pres = presented;
        np = 0;
        ns = 0;
        if (w > 0) begin
            for (int r = 0; r < nr; r++) begin
                for (int i = 0; i < w; i++) begin
                    k = r * w + i;
                    a = k % 64;
                    addr_q.push_back(a);
                    if (SKIP && (mem[a] == '0)) begin
                        ns++;
                    end else begin
                        word_q.push_back(mem[a]);
                        rnd_q.push_back(r);
                        pres++;
                        np++;
                    end
                    if (i == w - 1) er_q.push_back(pres);
                end
            end
        end
    endtask

    task automatic pulse_start(input int nr, input int w);
        @(posedge clk); #1;
        start = 1'b1;
        n_round = (CW+1)'(nr);
        wpr = AW'(w);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc, input bit chk_cyc);
        int cyc;
        cyc = 1;
        while (!end_weight && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done_reached", end_weight, 1);
        if (chk_cyc) check("cycles_to_done", cyc, exp_cyc);
        check("busy_in_done", busy, 0);
        @(posedge clk); #1;
        check("addr_q_drained", addr_q.size(), 0);
        check("word_q_drained", word_q.size(), 0);
        check("er_q_drained", er_q.size(), 0);
    endtask

    task automatic run(input int nr, input int w);
        int np;
        int ns;
        plan(nr, w, np, ns);
        pulse_start(nr, w);
        wait_done(1 + 3 * np + 2 * ns, 1'b1);
    endtask

    initial begin
        int np;
        int ns;
        int cyc;
        logic [31:0] snap;
        logic [31:0] save1;
        logic [31:0] save2;

        for (int a = 0; a < 64; a++)
            for (int l = 0; l < NR; l++) mem[a][l*FW +: FW] = FW'(a + l + 1);

        rst = 1'b1; start = 1'b0; ld = 1'b0; n_round = '0; wpr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_valid", valid, 0);
        check("rst_f_weight", fpack(), 0);
        check("rst_round", round, 0);
        check("rst_end_round", end_round, 0);
        check("rst_end_weight", end_weight, 0);
        check("rst_busy", busy, 0);

        // Basic: 2 rounds x 3 words, ld always high
        ld = 1'b1;
        run(2, 3);
        check("basic_round_final", round, 2);

        // Backpressure
        ld = 1'b0;
        plan(1, 2, np, ns);
        pulse_start(1, 2);
        check("busy_after_start", busy, 1);
        cyc = 1;
        while (!valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("valid_latency", cyc, 3);
        snap = fpack();
        check("bp_first_word", snap, mem[0]);
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_valid", valid, 1);
            check("bp_stable", fpack(), snap);
            check("bp_mem_rd", mem_rd, 0);
        end
        ld = 1'b1;
        wait_done(0, 1'b0);

        // Degenerate configurations
        run(0, 3);
        run(2, 0);

        // Address wrap
        run(2, 40);

        // Zero words 1 and 2 of a 4-word round
        save1 = mem[1];
        save2 = mem[2];
        mem[1] = '0;
        mem[2] = '0;
        run(1, 4);
        mem[1] = save1;
        mem[2] = save2;

        // Asynchronous reset in HOLD
        ld = 1'b0;
        plan(1, 4, np, ns);
        pulse_start(1, 4);
        cyc = 1;
        while (!valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("hold_before_reset", valid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_mem_rd", mem_rd, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_valid", valid, 0);
        check("arst_f_weight", fpack(), 0);
        check("arst_round", round, 0);
        check("arst_end_round", end_round, 0);
        check("arst_end_weight", end_weight, 0);
        check("arst_busy", busy, 0);
        addr_q.delete();
        word_q.delete();
        rnd_q.delete();
        er_q.delete();
        @(posedge clk); #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", valid, 0);
        check("post_rst_mem_rd", mem_rd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
